// File: rtl/uart_sram_loader_pkg.sv
// Shared types and default constants for the UART-to-SRAM loader.
// The loader's optional timeout build is selected with UART_LOADER_TIMEOUT_EN.
package uart_sram_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HI,
        S_GAP_HI,
        S_WAIT_LO,
        S_GAP_LO,
        S_WRITE
    } UART_loader_state_type;

    localparam int          DEFAULT_ADDR_W      = 18;
    localparam logic [17:0] DEFAULT_BASE_ADDR   = 18'd0;
    localparam logic [17:0] DEFAULT_NUM_WORDS   = 18'd76800;
    localparam logic [31:0] DEFAULT_TIMEOUT_CYC = 32'd50000000;

    function automatic logic is_wait_state(input UART_loader_state_type s);
        return (s == S_WAIT_HI) || (s == S_WAIT_LO);
    endfunction

endpackage

// File: rtl/uart_sram_loader.sv
// Drains bytes from the UART receiver, pairs them high byte first and writes the
// 16-bit words to consecutive SRAM addresses. Define UART_LOADER_TIMEOUT_EN for the idle timeout.
module uart_sram_loader
    import uart_sram_loader_pkg::*;
#(
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter logic [ADDR_W-1:0] NUM_WORDS   = ADDR_W'(DEFAULT_NUM_WORDS),
    parameter logic [31:0]       TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic              Error_overrun,
    output logic              Error_frame,
    output logic              Error_timeout,
    output logic [ADDR_W-1:0] Word_count,
    output logic              UART_rx_enable,
    output logic              UART_rx_unload_data,
    input  logic [7:0]        UART_rx_data,
    input  logic              UART_rx_empty,
    input  logic              UART_rx_overrun,
    input  logic [3:0]        UART_rx_frame_error,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [15:0]       SRAM_write_data,
    output logic              SRAM_we_n
);

    UART_loader_state_type state, state_next;

    logic [7:0]        hi_byte, hi_next;
    logic [7:0]        lo_byte, lo_next;
    logic              busy_next, done_next, ovr_next, frm_next, we_n_next;
    logic [ADDR_W-1:0] count_next, addr_next, count_inc;
    logic [15:0]       wdata_next;
    logic              capture;

    assign capture   = is_wait_state(state) && !UART_rx_empty;
    assign count_inc = Word_count + ADDR_W'(1);

`ifdef UART_LOADER_TIMEOUT_EN
    logic [31:0] timer, timer_next;
    logic        tmo_next;
    logic        timer_armed;

    // The timer only runs once a session has actually received data.
    assign timer_armed = (state == S_WAIT_LO) ||
                         ((state == S_WAIT_HI) && (Word_count != '0));
`endif

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_next          = state;
        hi_next             = hi_byte;
        lo_next             = lo_byte;
        busy_next           = Busy;
        done_next           = 1'b0;
        ovr_next            = Error_overrun;
        frm_next            = Error_frame;
        count_next          = Word_count;
        addr_next           = SRAM_address;
        wdata_next          = SRAM_write_data;
        we_n_next           = 1'b1;
        UART_rx_enable      = (state != S_IDLE);
        UART_rx_unload_data = 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
        timer_next          = timer;
        tmo_next            = Error_timeout;
`endif

        if (capture) begin
            UART_rx_unload_data = 1'b1;
            if (UART_rx_overrun)              ovr_next = 1'b1;
            if (UART_rx_frame_error != 4'd0)  frm_next = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (Start && !Abort) begin
                    count_next = '0;
                    ovr_next   = 1'b0;
                    frm_next   = 1'b0;
                    addr_next  = BASE_ADDR;
                    busy_next  = 1'b1;
                    state_next = S_WAIT_HI;
`ifdef UART_LOADER_TIMEOUT_EN
                    tmo_next   = 1'b0;
                    timer_next = '0;
`endif
                end
            end
            S_WAIT_HI: begin
                if (!UART_rx_empty) begin
                    hi_next    = UART_rx_data;
                    state_next = S_GAP_HI;
                end
            end
            S_GAP_HI: state_next = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!UART_rx_empty) begin
                    lo_next    = UART_rx_data;
                    state_next = S_GAP_LO;
                end
            end
            S_GAP_LO: begin
                // Registering the strobe here makes SRAM_we_n low for exactly the S_WRITE cycle.
                wdata_next = {hi_byte, lo_byte};
                we_n_next  = 1'b0;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                count_next = count_inc;
                addr_next  = SRAM_address + ADDR_W'(1);
                if (count_inc == NUM_WORDS) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT_HI;
                end
            end
            default: state_next = S_IDLE;
        endcase

`ifdef UART_LOADER_TIMEOUT_EN
        if (capture) begin
            timer_next = '0;
        end else if (timer_armed) begin
            if (timer == TIMEOUT_CYC - 32'd1) begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                tmo_next   = 1'b1;
            end else begin
                timer_next = timer + 32'd1;
            end
        end
`endif

        // Abort overrides everything, including a capture in the same cycle.
        if (Abort && (state != S_IDLE)) begin
            state_next          = S_IDLE;
            busy_next           = 1'b0;
            done_next           = 1'b0;
            we_n_next           = 1'b1;
            UART_rx_unload_data = 1'b0;
            count_next          = Word_count;
            addr_next           = SRAM_address;
            ovr_next            = Error_overrun;
            frm_next            = Error_frame;
`ifdef UART_LOADER_TIMEOUT_EN
            tmo_next            = Error_timeout;
`endif
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state           <= S_IDLE;
            hi_byte         <= 8'd0;
            lo_byte         <= 8'd0;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Error_overrun   <= 1'b0;
            Error_frame     <= 1'b0;
            Word_count      <= '0;
            SRAM_address    <= BASE_ADDR;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state           <= state_next;
            hi_byte         <= hi_next;
            lo_byte         <= lo_next;
            Busy            <= busy_next;
            Done            <= done_next;
            Error_overrun   <= ovr_next;
            Error_frame     <= frm_next;
            Word_count      <= count_next;
            SRAM_address    <= addr_next;
            SRAM_write_data <= wdata_next;
            SRAM_we_n       <= we_n_next;
        end
    end

`ifdef UART_LOADER_TIMEOUT_EN
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            timer         <= '0;
            Error_timeout <= 1'b0;
        end else begin
            timer         <= timer_next;
            Error_timeout <= tmo_next;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign Error_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sram_loader.sv
// Directed self-checking bench for uart_sram_loader with a small FIFO-style receiver model.
// The timeout scenario runs only when UART_LOADER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_sram_loader;

    localparam int                ADDR_W      = 18;
    localparam logic [ADDR_W-1:0] BASE_ADDR   = 18'd0;
    localparam logic [ADDR_W-1:0] NUM_WORDS   = 18'd2;
    localparam logic [31:0]       TIMEOUT_CYC = 32'd100;

    logic              Clock_50 = 1'b0;
    logic              Resetn;
    logic              Start;
    logic              Abort;
    logic              Busy, Done, Error_overrun, Error_frame, Error_timeout;
    logic [ADDR_W-1:0] Word_count;
    logic              UART_rx_enable, UART_rx_unload_data;
    logic [7:0]        UART_rx_data        = 8'd0;
    logic              UART_rx_empty       = 1'b1;
    logic              UART_rx_overrun     = 1'b0;
    logic [3:0]        UART_rx_frame_error = 4'd0;
    logic [ADDR_W-1:0] SRAM_address;
    logic [15:0]       SRAM_write_data;
    logic              SRAM_we_n;

    uart_sram_loader #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_WORDS  (NUM_WORDS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .Clock_50           (Clock_50),
        .Resetn             (Resetn),
        .Start              (Start),
        .Abort              (Abort),
        .Busy               (Busy),
        .Done               (Done),
        .Error_overrun      (Error_overrun),
        .Error_frame        (Error_frame),
        .Error_timeout      (Error_timeout),
        .Word_count         (Word_count),
        .UART_rx_enable     (UART_rx_enable),
        .UART_rx_unload_data(UART_rx_unload_data),
        .UART_rx_data       (UART_rx_data),
        .UART_rx_empty      (UART_rx_empty),
        .UART_rx_overrun    (UART_rx_overrun),
        .UART_rx_frame_error(UART_rx_frame_error),
        .SRAM_address       (SRAM_address),
        .SRAM_write_data    (SRAM_write_data),
        .SRAM_we_n          (SRAM_we_n)
    );

    always #10 Clock_50 = ~Clock_50;

    int cyc = 0;
    always @(posedge Clock_50) cyc++;

    // Receiver entries: [7:0] data, [8] overrun, [12:9] frame-error count.
    logic [12:0] rx_mem [0:31];
    int          rx_wr  = 0;
    int          popped = 0;

    // Monitor state, written only by the negedge monitor.
    int          unload_count    = 0;
    int          last_unload_cyc = 0;
    int          spacing_bad     = 0;
    int          done_count      = 0;
    int          wr_n            = 0;
    logic [33:0] wr_log [0:15];

    int total = 0;
    int bad   = 0;

    // Empty/data change just after the edge that consumed the unload, like the real receiver.
    always @(posedge Clock_50) begin
        #1;
        if (popped < unload_count && popped < rx_wr) popped++;
        if (popped < rx_wr) begin
            UART_rx_empty       = 1'b0;
            UART_rx_data        = rx_mem[popped][7:0];
            UART_rx_overrun     = rx_mem[popped][8];
            UART_rx_frame_error = rx_mem[popped][12:9];
        end else begin
            UART_rx_empty       = 1'b1;
            UART_rx_data        = 8'd0;
            UART_rx_overrun     = 1'b0;
            UART_rx_frame_error = 4'd0;
        end
    end

    always @(negedge Clock_50) begin
        if (UART_rx_unload_data) begin
            if (unload_count > 0 && (cyc - last_unload_cyc) < 2) spacing_bad++;
            last_unload_cyc = cyc;
            unload_count++;
        end
        if (!SRAM_we_n) begin
            if (wr_n < 16) wr_log[wr_n] = {SRAM_address, SRAM_write_data};
            wr_n++;
        end
        if (Done) done_count++;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock_50);
        #5;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic ovr, input logic [3:0] frm);
        rx_mem[rx_wr] = {frm, ovr, d};
        rx_wr++;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen, output int at_cyc);
        seen   = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (Done) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
    endtask

    task automatic wait_unload(input int base, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (unload_count > base) seen = 1'b1;
        end
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int t0, n0, w0, d0;
`ifdef UART_LOADER_TIMEOUT_EN
        int t_cap;
`endif
        Start  = 1'b0;
        Abort  = 1'b0;
        Resetn = 1'b0;
        repeat (3) tick();

        check("rst_busy",      Busy, 0);
        check("rst_done",      Done, 0);
        check("rst_overrun",   Error_overrun, 0);
        check("rst_frame",     Error_frame, 0);
        check("rst_timeout",   Error_timeout, 0);
        check("rst_count",     Word_count, 0);
        check("rst_addr",      SRAM_address, BASE_ADDR);
        check("rst_wdata",     SRAM_write_data, 0);
        check("rst_we_n",      SRAM_we_n, 1);
        check("rst_rx_enable", UART_rx_enable, 0);
        check("rst_unload",    UART_rx_unload_data, 0);

        Resetn = 1'b1;
        tick();

        // Session 1: all four bytes queued, so Empty stays low between captures.
        push_byte(8'h12, 1'b0, 4'd0);
        push_byte(8'h34, 1'b0, 4'd0);
        push_byte(8'h56, 1'b0, 4'd0);
        push_byte(8'h78, 1'b0, 4'd0);
        tick();
        n0 = unload_count; w0 = wr_n; d0 = done_count;
        pulse_start();
        check("s1_busy_after_start", Busy, 1);
        check("s1_rx_enable",        UART_rx_enable, 1);
        repeat (2) tick();
        pulse_start();
        wait_done(60, seen, t0);
        check("s1_done_seen",     seen, 1);
        check("s1_busy_at_done",  Busy, 0);
        check("s1_word_count",    Word_count, 2);
        check("s1_overrun",       Error_overrun, 0);
        check("s1_timeout",       Error_timeout, 0);
        tick();
        check("s1_done_one_cycle", Done, 0);
        check("s1_done_count",     done_count - d0, 1);
        check("s1_write_count",    wr_n - w0, 2);
        check("s1_write0",         wr_log[w0],     {18'd0, 16'h1234});
        check("s1_write1",         wr_log[w0 + 1], {18'd1, 16'h5678});
        check("s1_unload_count",   unload_count - n0, 4);
        check("s1_unload_spacing", spacing_bad, 0);
        check("s1_addr_after",     SRAM_address, 2);
        check("s1_rx_enable_idle", UART_rx_enable, 0);

        // Session 2: overrun flagged on the second captured byte.
        push_byte(8'hAB, 1'b0, 4'd0);
        push_byte(8'hCD, 1'b1, 4'd0);
        push_byte(8'hEF, 1'b0, 4'd0);
        push_byte(8'h01, 1'b0, 4'd0);
        tick();
        w0 = wr_n;
        pulse_start();
        check("s2_addr_restart", SRAM_address, BASE_ADDR);
        wait_done(60, seen, t0);
        check("s2_done_seen",  seen, 1);
        check("s2_overrun",    Error_overrun, 1);
        check("s2_frame",      Error_frame, 0);
        check("s2_word_count", Word_count, 2);
        check("s2_write0",     wr_log[w0],     {18'd0, 16'hABCD});
        check("s2_write1",     wr_log[w0 + 1], {18'd1, 16'hEF01});

        // Session 3: Start clears the sticky overrun; frame error on byte two.
        push_byte(8'h11, 1'b0, 4'd0);
        push_byte(8'h22, 1'b0, 4'd3);
        push_byte(8'h33, 1'b0, 4'd0);
        push_byte(8'h44, 1'b0, 4'd0);
        tick();
        w0 = wr_n;
        pulse_start();
        check("s3_overrun_cleared", Error_overrun, 0);
        check("s3_count_cleared",   Word_count, 0);
        wait_done(60, seen, t0);
        check("s3_done_seen", seen, 1);
        check("s3_frame",     Error_frame, 1);
        check("s3_overrun",   Error_overrun, 0);
        check("s3_write0",    wr_log[w0],     {18'd0, 16'h1122});
        check("s3_write1",    wr_log[w0 + 1], {18'd1, 16'h3344});

        // Abort after one byte.
        push_byte(8'h99, 1'b0, 4'd0);
        tick();
        n0 = unload_count; w0 = wr_n; d0 = done_count;
        pulse_start();
        wait_unload(n0, 20, seen);
        check("ab_first_unload", seen, 1);
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("ab_busy",      Busy, 0);
        check("ab_rx_enable", UART_rx_enable, 0);
        check("ab_count",     Word_count, 0);
        repeat (5) tick();
        check("ab_no_write", wr_n - w0, 0);
        check("ab_no_done",  done_count - d0, 0);
        check("ab_we_n",     SRAM_we_n, 1);

        // Start and Abort together in idle: Abort wins.
        push_byte(8'h55, 1'b0, 4'd0);
        push_byte(8'h66, 1'b0, 4'd0);
        tick();
        n0 = unload_count;
        Start = 1'b1; Abort = 1'b1;
        tick();
        Start = 1'b0; Abort = 1'b0;
        check("sa_busy",      Busy, 0);
        check("sa_rx_enable", UART_rx_enable, 0);
        repeat (4) tick();
        check("sa_no_unload", unload_count - n0, 0);

        // Reset asserted while the write strobe is low.
        w0 = wr_n;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (!SRAM_we_n) seen = 1'b1;
        end
        check("rw_reached_write", seen, 1);
        check("rw_wdata_before",  SRAM_write_data, 16'h5566);
        Resetn = 1'b0;
        #1;
        check("rw_we_n",      SRAM_we_n, 1);
        check("rw_busy",      Busy, 0);
        check("rw_done",      Done, 0);
        check("rw_count",     Word_count, 0);
        check("rw_addr",      SRAM_address, BASE_ADDR);
        check("rw_wdata",     SRAM_write_data, 0);
        check("rw_rx_enable", UART_rx_enable, 0);
        check("rw_unload",    UART_rx_unload_data, 0);
        tick();
        Resetn = 1'b1;
        repeat (6) tick();
        check("rw_no_write_after", wr_n - w0, 0);
        check("rw_stays_idle",     Busy, 0);

`ifdef UART_LOADER_TIMEOUT_EN
        // One byte then silence: the idle timer ends the session.
        push_byte(8'h77, 1'b0, 4'd0);
        tick();
        n0 = unload_count; w0 = wr_n;
        pulse_start();
        wait_unload(n0, 20, seen);
        check("to_first_unload", seen, 1);
        t_cap = last_unload_cyc + 1;
        wait_done(150, seen, t0);
        check("to_done_seen", seen, 1);
        check("to_error",     Error_timeout, 1);
        check("to_busy",      Busy, 0);
        check("to_no_write",  wr_n - w0, 0);
        check("to_latency_window", ((t0 - t_cap) >= 95) && ((t0 - t_cap) <= 105), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_sram_loader.md
Name: uart_sram_loader

Overview:
- Sequencer for the UART receive controller. Enables the receiver, drains received bytes with single-cycle unload pulses, and pairs bytes into 16-bit words, high byte first.
- Writes each word to external SRAM at consecutive addresses from BASE_ADDR until NUM_WORDS words are stored.
- Sits between the UART receiver and the SRAM controller's write port. Top-level FSM starts it with Start and observes Done/Busy/status.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- BASE_ADDR, 18'd0, first SRAM word address written.
- NUM_WORDS, 18'd76800, words loaded per session (must be >= 1).
- TIMEOUT_CYC, 32'd50000000, idle cycles before a timeout abort (optional feature only).

Ports:
- Clock_50  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request to begin a load session.
- Abort  in  1  one-cycle request to stop the session.
- Busy  out  1  session in progress.
- Done  out  1  high for one cycle when the last word has been written.
- Error_overrun  out  1  sticky: receiver reported overrun during the session.
- Error_frame  out  1  sticky: receiver frame-error count was nonzero during the session.
- Error_timeout  out  1  sticky: session ended by timeout (optional feature).
- Word_count  out  ADDR_W  words written this session.
- UART_rx_enable  out  1  to receiver Enable.
- UART_rx_unload_data  out  1  to receiver Unload_data.
- UART_rx_data  in  8  receiver RX_data.
- UART_rx_empty  in  1  receiver Empty.
- UART_rx_overrun  in  1  receiver Overrun.
- UART_rx_frame_error  in  4  receiver Frame_error count.
- SRAM_address  out  ADDR_W  write address.
- SRAM_write_data  out  16  write data.
- SRAM_we_n  out  1  active-low write enable.

Behaviour:
- Reset values:
  - Registered outputs: Busy=0, Done=0, all Error_*=0, Word_count=0, SRAM_address=BASE_ADDR, SRAM_write_data=0, SRAM_we_n=1.
  - Combinational outputs from state: UART_rx_enable=0, UART_rx_unload_data=0 (S_IDLE).
  - State = S_IDLE.
- Reset mid-operation returns to S_IDLE immediately; no partial word is written afterwards.
- States:
  - S_IDLE: Start -> clear Word_count and Error_*; SRAM_address=BASE_ADDR; Busy=1; go to S_WAIT_HI.
  - S_WAIT_HI: UART_rx_enable=1. When UART_rx_empty=0: capture UART_rx_data into the high byte, pulse UART_rx_unload_data for this cycle only, go to S_GAP_HI.
  - S_GAP_HI: one cycle so Empty reflects the unload, then go to S_WAIT_LO.
  - S_WAIT_LO / S_GAP_LO: same as the HI pair, capturing the low byte. S_GAP_LO goes to S_WRITE.
  - S_WRITE: SRAM_write_data={hi,lo}; SRAM_we_n=0 for exactly one cycle at the current SRAM_address.
    - On the next edge: Word_count+1, SRAM_address+1.
    - If Word_count+1==NUM_WORDS: Done=1 (one cycle), Busy=0, go to S_IDLE.
    - Otherwise go to S_WAIT_HI.
- UART_rx_enable is high in every state except S_IDLE.
- Byte capture latency: data captured on the cycle Empty is seen low. The unload pulse is one cycle. The earliest next capture is 2 cycles later.
- Error sampling, at each capture cycle:
  - UART_rx_overrun=1 -> Error_overrun=1.
  - UART_rx_frame_error!=0 -> Error_frame=1.
  - Errors do not stop the load.
- Start while Busy=1 is ignored.
- Abort has priority over all transitions in any non-idle state: go to S_IDLE with SRAM_we_n=1, Busy=0, no Done. Word_count holds its value.
- Simultaneous Start and Abort in S_IDLE: Abort wins, so the session does not start.
- SRAM_address wraps modulo 2^ADDR_W. NUM_WORDS is not checked against the wrap.

Optional Feature:
- Macro UART_LOADER_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on each byte capture and on Start, and increments in the S_WAIT_* states once Word_count>0 or the high byte is held.
  - Reaching TIMEOUT_CYC-1 ends the session as Abort does, and additionally sets Error_timeout=1 and pulses Done.
- When undefined: no counter; Error_timeout is tied to 0; waits are unbounded.

Decomposition:
- Shared package (define_state.h): typedef enum UART_loader_state_type {S_IDLE, S_WAIT_HI, S_GAP_HI, S_WAIT_LO, S_GAP_LO, S_WRITE}.
- Shared constants: default NUM_WORDS, BASE_ADDR.
- No sub-module needed. The timeout counter stays inline.

Test Plan:
- NUM_WORDS=2; Start; bytes 0x12,0x34,0x56,0x78 -> writes 0x1234 @0 and 0x5678 @1, one Done pulse, Busy low, Word_count=2.
- Receiver model holds Empty=0 continuously -> exactly one unload pulse per capture, captures spaced >=2 cycles apart, no duplicate bytes.
- Overrun=1 at the second capture -> Error_overrun=1 at Done, data still written. Next Start clears it to 0.
- Abort after one byte -> SRAM_we_n never low, Busy=0, no Done, Word_count=0.
- Resetn low during S_WRITE -> SRAM_we_n=1 and state S_IDLE immediately, all outputs at reset values.
- With UART_LOADER_TIMEOUT_EN, TIMEOUT_CYC=100: one byte then silence -> Error_timeout=1, Done pulse at capture+100 cycles, no write.
